pineball_motion_engine: RTL and testbench

//  Parametrised successor to pineball_data: frame-paced bouncing-ball position engine for the VGA pinball demo.

---
 rtl/pineball_motion_engine.sv | 209 ++++++++++++++++++++
 tb/tb_pineball_motion_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pineball_motion_engine.sv
// Frame-paced bouncing-ball position engine.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | ball parked at INIT, waiting for launch
//   ST_MOVE   | ball steps once per frame_tick while run is high
//   ST_LOST   | ball missed at the bottom; frozen until the respawn timeout
module pineball_motion_engine #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SZ     = 8,
  parameter int SPD_W       = 4,
  parameter int INIT_X      = 316,
  parameter int INIT_Y      = 236,
  parameter int BOTTOM_MISS = 1,
  parameter int LOST_FRAMES = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             run,
  input  logic             launch,
  input  logic [SPD_W-1:0] spd_x_in,
  input  logic [SPD_W-1:0] spd_y_in,
  input  logic             dir_x_in,
  input  logic             dir_y_in,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic [3:0]       hit_edge,
  output logic             miss,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MOVE = 2'd1, ST_LOST = 2'd2} state_t;

  localparam int LC_W = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;
  localparam logic [X_W:0]    X_MAX  = (X_W+1)'(H_RES - BALL_SZ);
  localparam logic [Y_W:0]    Y_MAX  = (Y_W+1)'(V_RES - BALL_SZ);
  localparam logic [X_W-1:0]  X_INIT = X_W'(INIT_X);
  localparam logic [Y_W-1:0]  Y_INIT = Y_W'(INIT_Y);
  localparam logic [LC_W-1:0] LC_END = LC_W'(LOST_FRAMES - 1);

  state_t           state_q, state_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [SPD_W-1:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
  logic [3:0]       hit_q, hit_d;
  logic             miss_q, miss_d;
  logic [LC_W-1:0]  lost_q, lost_d;

  logic [X_W:0]   x_ext, x_spd, x_sum, x_dif;
  logic [Y_W:0]   y_ext, y_spd, y_sum, y_dif;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           x_dnxt, y_dnxt, hit_l, hit_r, hit_t, hit_b;

  // Candidate one-frame step for each axis; sums carry an extra bit so nothing wraps.
  always_comb begin
    x_ext  = {1'b0, pos_x_q};
    x_spd  = (X_W+1)'(spd_x_q);
    x_sum  = x_ext + x_spd;
    x_dif  = x_ext - x_spd;
    x_nxt  = pos_x_q;
    x_dnxt = dir_x_q;
    hit_l  = 1'b0;
    hit_r  = 1'b0;
    if (spd_x_q != '0) begin
      if (dir_x_q) begin
        if (x_sum >= X_MAX) begin
          x_nxt  = X_MAX[X_W-1:0];
          x_dnxt = 1'b0;
          hit_r  = 1'b1;
        end else begin
          x_nxt = x_sum[X_W-1:0];
        end
      end else if (x_ext <= x_spd) begin
        x_nxt  = '0;
        x_dnxt = 1'b1;
        hit_l  = 1'b1;
      end else begin
        x_nxt = x_dif[X_W-1:0];
      end
    end

    y_ext  = {1'b0, pos_y_q};
    y_spd  = (Y_W+1)'(spd_y_q);
    y_sum  = y_ext + y_spd;
    y_dif  = y_ext - y_spd;
    y_nxt  = pos_y_q;
    y_dnxt = dir_y_q;
    hit_t  = 1'b0;
    hit_b  = 1'b0;
    if (spd_y_q != '0) begin
      if (dir_y_q) begin
        if (y_sum >= Y_MAX) begin
          y_nxt  = Y_MAX[Y_W-1:0];
          y_dnxt = 1'b0;
          hit_b  = 1'b1;
        end else begin
          y_nxt = y_sum[Y_W-1:0];
        end
      end else if (y_ext <= y_spd) begin
        y_nxt  = '0;
        y_dnxt = 1'b1;
        hit_t  = 1'b1;
      end else begin
        y_nxt = y_dif[Y_W-1:0];
      end
    end
  end

  // Next-state and registered-output decisions.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    spd_x_d = spd_x_q;
    spd_y_d = spd_y_q;
    lost_d  = lost_q;
    hit_d   = 4'b0000;
    miss_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pos_x_d = X_INIT;
        pos_y_d = Y_INIT;
        if (launch) begin
          spd_x_d = spd_x_in;
          spd_y_d = spd_y_in;
          dir_x_d = dir_x_in;
          dir_y_d = dir_y_in;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (frame_tick && run) begin
          pos_x_d = x_nxt;
          dir_x_d = x_dnxt;
          pos_y_d = y_nxt;
          dir_y_d = y_dnxt;
          hit_d   = {hit_b, hit_t, hit_r, hit_l};
          // A bottom miss keeps dir_y pointing down; the respawn resets it.
          if (hit_b && (BOTTOM_MISS != 0)) begin
            dir_y_d = dir_y_q;
            miss_d  = 1'b1;
            state_d = ST_LOST;
          end
        end
      end
      ST_LOST: begin
        if (frame_tick) begin
          if (lost_q == LC_END) begin
            lost_d  = '0;
            pos_x_d = X_INIT;
            pos_y_d = Y_INIT;
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            lost_d = lost_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_x_q <= X_INIT;
      pos_y_q <= Y_INIT;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      spd_x_q <= '0;
      spd_y_q <= '0;
      hit_q   <= 4'b0000;
      miss_q  <= 1'b0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      spd_x_q <= spd_x_d;
      spd_y_q <= spd_y_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      lost_q  <= lost_d;
    end
  end

  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign dir_x    = dir_x_q;
  assign dir_y    = dir_y_q;
  assign hit_edge = hit_q;
  assign miss     = miss_q;
  assign state    = state_q;

endmodule

// File: tb/tb_pineball_motion_engine.sv
// Bench for pineball_motion_engine: integer-level ball model checked every
// cycle, plus hand-computed literal checkpoints for the directed scenarios.
module tb_pineball_motion_engine;

  localparam int XMAX = 632;
  localparam int YMAX = 472;
  localparam int IX   = 316;
  localparam int IY   = 236;
  localparam int LOSTN = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       run = 1'b1;
  logic       launch = 1'b0;
  logic [3:0] spd_x_in = '0;
  logic [3:0] spd_y_in = '0;
  logic       dir_x_in = 1'b1;
  logic       dir_y_in = 1'b1;
  logic [9:0] pos_x, pos_y;
  logic       dir_x, dir_y, miss;
  logic [3:0] hit_edge;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  pineball_motion_engine dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .launch(launch),
    .spd_x_in(spd_x_in), .spd_y_in(spd_y_in), .dir_x_in(dir_x_in), .dir_y_in(dir_y_in),
    .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y),
    .hit_edge(hit_edge), .miss(miss), .state(state)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 moving, 2 lost
  int m_x = IX, m_y = IY, m_sx = 0, m_sy = 0, m_dx = 1, m_dy = 1;
  int m_st = 0, m_lost = 0, m_hit = 0, m_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: ball rules evaluated in plain integers.
  always @(posedge clk) begin
    m_hit  = 0;
    m_miss = 0;
    if (!rst_n) begin
      m_x = IX; m_y = IY; m_dx = 1; m_dy = 1; m_sx = 0; m_sy = 0;
      m_st = 0; m_lost = 0;
    end else if (m_st == 0) begin
      if (launch) begin
        m_sx = int'(spd_x_in); m_sy = int'(spd_y_in);
        m_dx = int'(dir_x_in); m_dy = int'(dir_y_in);
        m_st = 1;
      end
    end else if (m_st == 1) begin
      if (frame_tick && run) begin
        if (m_sx > 0) begin
          if (m_dx == 1) begin
            if (m_x + m_sx >= XMAX) begin m_x = XMAX; m_dx = 0; m_hit += 2; end
            else m_x = m_x + m_sx;
          end else begin
            if (m_x <= m_sx) begin m_x = 0; m_dx = 1; m_hit += 1; end
            else m_x = m_x - m_sx;
          end
        end
        if (m_sy > 0) begin
          if (m_dy == 1) begin
            if (m_y + m_sy >= YMAX) begin
              m_y = YMAX; m_hit += 8; m_miss = 1; m_st = 2;
            end else m_y = m_y + m_sy;
          end else begin
            if (m_y <= m_sy) begin m_y = 0; m_dy = 1; m_hit += 4; end
            else m_y = m_y - m_sy;
          end
        end
      end
    end else begin
      if (frame_tick) begin
        m_lost++;
        if (m_lost == LOSTN) begin
          m_lost = 0; m_x = IX; m_y = IY; m_dx = 1; m_dy = 1; m_st = 0;
        end
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("pos_x", int'(pos_x), m_x);
    chk("pos_y", int'(pos_y), m_y);
    chk("dir_x", int'(dir_x), m_dx);
    chk("dir_y", int'(dir_y), m_dy);
    chk("hit_edge", int'(hit_edge), m_hit);
    chk("miss", int'(miss), m_miss);
    chk("state", int'(state), m_st);
  end

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_launch(input int sx, input int sy, input bit dx, input bit dy, input bit ft);
    @(negedge clk);
    launch = 1'b1; frame_tick = ft;
    spd_x_in = 4'(sx); spd_y_in = 4'(sy); dir_x_in = dx; dir_y_in = dy;
    @(negedge clk);
    launch = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pos_x", int'(pos_x), 316);
    chk("rst_pos_y", int'(pos_y), 236);
    chk("rst_state", int'(state), 0);
    chk("rst_dirs", int'({dir_x, dir_y}), 3);
    chk("rst_hit", int'(hit_edge), 0);
    chk("rst_miss", int'(miss), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    run = 1'b1;
    do_reset();

    // right wall, launch coinciding with a frame tick
    do_launch(4, 0, 1'b1, 1'b1, 1'b1);
    chk("launch_tick_no_move", int'(pos_x), 316);
    ticks(78);
    chk("x_before_right", int'(pos_x), 628);
    tick();
    chk("x_right", int'(pos_x), 632);
    chk("hit_right", int'(hit_edge), 2);
    chk("dir_x_flip", int'(dir_x), 0);
    @(negedge clk);
    chk("hit_right_clear", int'(hit_edge), 0);
    tick();
    chk("x_back", int'(pos_x), 628);
    chk("y_still", int'(pos_y), 236);

    // top wall
    do_reset();
    do_launch(0, 5, 1'b1, 1'b0, 1'b0);
    ticks(47);
    chk("y_before_top", int'(pos_y), 1);
    tick();
    chk("y_top", int'(pos_y), 0);
    chk("hit_top", int'(hit_edge), 4);
    chk("dir_y_flip", int'(dir_y), 1);

    // bottom miss and respawn; run and launch ignored while lost
    do_reset();
    do_launch(0, 4, 1'b1, 1'b1, 1'b0);
    ticks(59);
    chk("y_bottom", int'(pos_y), 472);
    chk("miss_pulse", int'(miss), 1);
    chk("hit_bottom", int'(hit_edge), 8);
    chk("lost_state", int'(state), 2);
    run = 1'b0;
    ticks(30);
    do_launch(9, 9, 1'b0, 1'b0, 1'b0);
    ticks(29);
    chk("still_lost", int'(state), 2);
    chk("lost_frozen", int'(pos_y), 472);
    tick();
    chk("respawn_state", int'(state), 0);
    chk("respawn_x", int'(pos_x), 316);
    chk("respawn_y", int'(pos_y), 236);
    run = 1'b1;

    // corner: right and top on the same tick
    do_reset();
    do_launch(8, 6, 1'b1, 1'b0, 1'b0);
    ticks(40);
    chk("corner_hit", int'(hit_edge), 6);
    chk("corner_pos", int'({22'd0, pos_x} * 1000 + int'(pos_y)), 632000);

    // pause, ignored launch in MOVE, then mid-flight reset
    do_reset();
    do_launch(3, 2, 1'b1, 1'b1, 1'b0);
    ticks(5);
    chk("run_x", int'(pos_x), 331);
    chk("run_y", int'(pos_y), 246);
    run = 1'b0;
    ticks(10);
    do_launch(9, 9, 1'b0, 1'b0, 1'b1);
    chk("pause_x", int'(pos_x), 331);
    chk("pause_y", int'(pos_y), 246);
    run = 1'b1;
    tick();
    chk("resume_x", int'(pos_x), 334);
    chk("resume_y", int'(pos_y), 248);
    chk("resume_dir", int'({dir_x, dir_y}), 3);
    do_reset();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
